// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM states and
// the operand-usage decode used by the hazard logic.
package pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

  // R-type ops, stores and compares read the second source register
  function automatic logic uses_rs2(input logic [3:0] opcode);
    logic use_s;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, OP_SW, OP_BEQ: use_s = 1'b1;
      default: use_s = 1'b0;
    endcase
    return use_s;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the EX-stage load and the ID-stage
// source operands. Register r0 is hardwired and never hazards.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_rd,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  output logic       load_use
);

  logic rs1_match_s;
  logic rs2_match_s;

  assign rs1_match_s = (ex_rd == id_rs1);
  assign rs2_match_s = uses_rs2(id_opcode) && (ex_rd == id_rs2);
  assign load_use    = (ex_opcode == OP_LW) && (ex_rd != 4'd0) &&
                       (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 4-stage pipeline: load-use stalls, taken-branch
// flush penalty, HALT, memory-busy freeze and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_busy,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic [3:0]       ex_opcode,
  input  logic [3:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic [15:0]      ex_br_target,
  output logic             pc_write_en,
  output logic             pc_redirect,
  output logic [15:0]      redirect_pc,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0]       PEN_LOAD = 3'(BR_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t        state_r;
  hz_state_t        state_nxt_s;
  logic [2:0]       flush_cnt_r;
  logic [2:0]       flush_cnt_nxt_s;
  logic [15:0]      redirect_pc_r;
  logic [CNT_W-1:0] stall_count_r;
  logic             load_use_s;
  logic             cnt_inc_s;
  logic             redirect_ld_s;

  hazard_detect u_hazard_detect (
    .ex_opcode (ex_opcode),
    .ex_rd     (ex_rd),
    .id_opcode (id_opcode),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .load_use  (load_use_s)
  );

  // Prioritised control decode and next-state selection
  always_comb begin
    pc_write_en     = 1'b0;
    pc_redirect     = 1'b0;
    ifid_hold       = 1'b0;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    halted          = 1'b0;
    cnt_inc_s       = 1'b0;
    redirect_ld_s   = 1'b0;
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    if (reset) begin
      ifid_hold = 1'b1;
    end else begin
      halted = (state_r == HALT);
      if (mem_busy) begin
        ifid_hold = 1'b1;
        cnt_inc_s = 1'b1;
      end else if (state_r == HALT) begin
        ifid_hold = 1'b1;
      end else if (ex_br_taken) begin
        pc_redirect     = 1'b1;
        pc_write_en     = 1'b1;
        ifid_flush      = 1'b1;
        idex_bubble     = 1'b1;
        cnt_inc_s       = 1'b1;
        redirect_ld_s   = 1'b1;
        flush_cnt_nxt_s = PEN_LOAD;
        state_nxt_s     = (BR_PENALTY > 1) ? FLUSH : RUN;
      end else if (state_r == FLUSH) begin
        ifid_flush  = 1'b1;
        pc_write_en = 1'b1;
        cnt_inc_s   = 1'b1;
        if (flush_cnt_r <= 3'd1) begin
          flush_cnt_nxt_s = 3'd0;
          state_nxt_s     = RUN;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end else if (load_use_s) begin
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        cnt_inc_s   = 1'b1;
      end else if (id_opcode == OP_HALT) begin
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        cnt_inc_s   = 1'b1;
        state_nxt_s = HALT;
      end else begin
        pc_write_en = 1'b1;
      end
    end
  end

  // State, penalty counter, redirect target and stall counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= RUN;
      flush_cnt_r   <= 3'd0;
      redirect_pc_r <= 16'h0000;
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      if (redirect_ld_s) begin
        redirect_pc_r <= ex_br_target;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
      if (cnt_inc_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign redirect_pc = redirect_pc_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl (BR_PENALTY=2, CNT_W=4) with a
// queue scoreboard: expectations are pushed on drive and popped at mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] ADDI = 4'hC;
  localparam logic [3:0] LW   = 4'h8;
  localparam logic [3:0] SW   = 4'h9;
  localparam logic [3:0] HLT  = 4'hF;

  // ctl bit order: {pc_write_en, pc_redirect, ifid_hold, ifid_flush, idex_bubble, halted}
  localparam logic [5:0] C_RST  = 6'b001000;
  localparam logic [5:0] C_RUN  = 6'b100000;
  localparam logic [5:0] C_LU   = 6'b001010;
  localparam logic [5:0] C_BR   = 6'b110110;
  localparam logic [5:0] C_FL   = 6'b100100;
  localparam logic [5:0] C_HLTD = 6'b001010;
  localparam logic [5:0] C_HALT = 6'b001001;

  typedef struct {
    logic        rst;
    logic        busy;
    logic [3:0]  idop;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  exop;
    logic [3:0]  exrd;
    logic        br;
    logic [15:0] tgt;
    logic [5:0]  ctl;
    logic [3:0]  cnt;
    logic [15:0] rpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_busy = 1'b0;
  logic [3:0]  id_opcode = 4'h0;
  logic [3:0]  id_rs1 = 4'h0;
  logic [3:0]  id_rs2 = 4'h0;
  logic [3:0]  ex_opcode = 4'h0;
  logic [3:0]  ex_rd = 4'h0;
  logic        ex_br_taken = 1'b0;
  logic [15:0] ex_br_target = 16'h0000;
  logic        pc_write_en;
  logic        pc_redirect;
  logic [15:0] redirect_pc;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halted;
  logic [3:0]  stall_count;

  int   n_vec = 0;
  int   n_miss = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  pipeline_hazard_ctrl #(.BR_PENALTY(2), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_busy     (mem_busy),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_opcode    (ex_opcode),
    .ex_rd        (ex_rd),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .pc_write_en  (pc_write_en),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .halted       (halted),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic busy, input logic [3:0] idop,
                              input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] exop, input logic [3:0] exrd,
                              input logic br, input logic [15:0] tgt,
                              input logic [5:0] ctl, input logic [3:0] cnt,
                              input logic [15:0] rpc);
    vec_t v;
    v.rst = rst; v.busy = busy; v.idop = idop; v.rs1 = rs1; v.rs2 = rs2;
    v.exop = exop; v.exrd = exrd; v.br = br; v.tgt = tgt;
    v.ctl = ctl; v.cnt = cnt; v.rpc = rpc;
    return v;
  endfunction

  task automatic check_one();
    vec_t       e;
    logic [5:0] act;
    e   = exp_q.pop_front();
    act = {pc_write_en, pc_redirect, ifid_hold, ifid_flush, idex_bubble, halted};
    n_vec++;
    if (act !== e.ctl || stall_count !== e.cnt || redirect_pc !== e.rpc) begin
      n_miss++;
      $display("FAIL vec%0d: got ctl=%b cnt=%h rpc=%h, want ctl=%b cnt=%h rpc=%h",
               n_vec - 1, act, stall_count, redirect_pc, e.ctl, e.cnt, e.rpc);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset        = v.rst;
    mem_busy     = v.busy;
    id_opcode    = v.idop;
    id_rs1       = v.rs1;
    id_rs2       = v.rs2;
    ex_opcode    = v.exop;
    ex_rd        = v.exrd;
    ex_br_taken  = v.br;
    ex_br_target = v.tgt;
    exp_q.push_back(v);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    // reset and load-use / no-false-hazard cases
    vecs.push_back(mk(1, 0, NOP,  0, 0, NOP, 0, 0, 16'h0000, C_RST, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  3, 4, LW,  3, 0, 16'h0000, C_LU,  4'd0, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  3, 4, NOP, 0, 0, 16'h0000, C_RUN, 4'd1, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 3, LW,  3, 0, 16'h0000, C_LU,  4'd1, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  0, 0, LW,  0, 0, 16'h0000, C_RUN, 4'd2, 16'h0000));
    vecs.push_back(mk(0, 0, ADDI, 1, 5, LW,  5, 0, 16'h0000, C_RUN, 4'd2, 16'h0000));
    vecs.push_back(mk(0, 0, SW,   1, 5, LW,  5, 0, 16'h0000, C_LU,  4'd2, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 5, NOP, 0, 0, 16'h0000, C_RUN, 4'd3, 16'h0000));
    // branch penalty; FLUSH ignores HALT and load-use in ID
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 1, 16'h0040, C_BR,  4'd3, 16'h0000));
    vecs.push_back(mk(0, 0, HLT,  3, 3, LW,  3, 0, 16'h0000, C_FL,  4'd4, 16'h0040));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd5, 16'h0040));
    // second branch in FLUSH restarts the penalty
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 1, 16'h0080, C_BR,  4'd5, 16'h0040));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 1, 16'h00C0, C_BR,  4'd6, 16'h0080));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_FL,  4'd7, 16'h00C0));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd8, 16'h00C0));
    // mem_busy beats branch; branch beats load-use
    vecs.push_back(mk(0, 1, ADD,  1, 2, NOP, 0, 1, 16'h1234, C_RST, 4'd8, 16'h00C0));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd9, 16'h00C0));
    vecs.push_back(mk(0, 0, ADD,  3, 2, LW,  3, 1, 16'h0010, C_BR,  4'd9, 16'h00C0));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_FL,  4'd10, 16'h0010));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd11, 16'h0010));
    // reset in the middle of FLUSH
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 1, 16'h0050, C_BR,  4'd11, 16'h0010));
    vecs.push_back(mk(1, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RST, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd0, 16'h0000));
    // HALT is sticky, even against a branch
    vecs.push_back(mk(0, 0, HLT,  1, 2, NOP, 0, 0, 16'h0000, C_HLTD, 4'd0, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_HALT, 4'd1, 16'h0000));
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 1, 16'h2222, C_HALT, 4'd1, 16'h0000));
    // 20 frozen cycles saturate the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      vecs.push_back(mk(0, 1, ADD, 1, 2, NOP, 0, 0, 16'h0000, C_HALT,
                        (k + 1 > 15) ? 4'd15 : 4'(k + 1), 16'h0000));
    end
    vecs.push_back(mk(0, 0, ADD,  1, 2, NOP, 0, 0, 16'h0000, C_HALT, 4'd15, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // only reset leaves HALT
    apply(mk(1, 0, NOP, 0, 0, NOP, 0, 0, 16'h0000, C_RST, 4'd0, 16'h0000));
    apply(mk(0, 0, ADD, 1, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd0, 16'h0000));
    apply(mk(0, 0, ADD, 7, 2, LW,  7, 0, 16'h0000, C_LU,  4'd0, 16'h0000));
    apply(mk(0, 0, ADD, 7, 2, NOP, 0, 0, 16'h0000, C_RUN, 4'd1, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
